// File: rtl/alu_share_if.sv
// Bus bundle between the ALU share arbiter and its environment: two request
// ports, the ALU mux operand/result lines and the tagged response channel.
interface alu_share_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req0_c;
  logic [1:0]       req0_sel;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] req1_c;
  logic [1:0]       req1_sel;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_c;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_y;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  logic             busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c, req0_sel,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_c, req1_sel,
    output req1_ready,
    output alu_a, alu_b, alu_c, alu_sel,
    input  alu_y,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready,
    output busy
  );

  // Requesters, ALU mux and response consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_c, req0_sel,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_c, req1_sel,
    input  req1_ready,
    input  alu_a, alu_b, alu_c, alu_sel,
    output alu_y,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU mux between the execute stage (port 0) and the
// debug/DMA side (port 1); one operation in flight, response tagged by port.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_share_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic             ptr_reg;   // 1 = port 1 wins a tie
  logic             id_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic [WIDTH-1:0] alu_c_reg;
  logic [1:0]       alu_sel_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_id_reg;
  logic             rsp_valid_reg;

  logic grant0;
  logic grant1;

  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || !ptr_reg);
    grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr_reg);
  end

  assign bus.req0_ready = (state_reg == IDLE) && grant0;
  assign bus.req1_ready = (state_reg == IDLE) && grant1;
  assign bus.busy       = (state_reg != IDLE);

  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.alu_c     = alu_c_reg;
  assign bus.alu_sel   = alu_sel_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_valid = rsp_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      id_reg        <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_c_reg     <= '0;
      alu_sel_reg   <= 2'b00;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a_reg   <= grant1 ? bus.req1_a   : bus.req0_a;
            alu_b_reg   <= grant1 ? bus.req1_b   : bus.req0_b;
            alu_c_reg   <= grant1 ? bus.req1_c   : bus.req0_c;
            alu_sel_reg <= grant1 ? bus.req1_sel : bus.req0_sel;
            id_reg      <= grant1;
            // Next tie goes to whichever port was not just served
            ptr_reg     <= !grant1;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_reg  <= bus.alu_y;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU mux on alu_*.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_share_if #(.WIDTH(32)) bus ();

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ALU mux: 00/01 pass c, 10 a&b, 11 a|b
  assign bus.alu_y = bus.alu_sel[1] ? (bus.alu_sel[0] ? (bus.alu_a | bus.alu_b)
                                                      : (bus.alu_a & bus.alu_b))
                                    : bus.alu_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_c = '0; bus.req0_sel = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_c = '0; bus.req1_sel = 2'b00;
    bus.rsp_ready  = 1'b0;

    // Reset state
    #12;
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data",  bus.rsp_data,           32'd0);
    chk("rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
    chk("rst_alu_a",     bus.alu_a,              32'd0);
    chk("rst_alu_sel",   {30'd0, bus.alu_sel},   32'd0);
    rst_n = 1'b1;
    tick();

    // Single port-0 AND operation
    bus.req0_valid = 1'b1; bus.req0_sel = 2'b10;
    bus.req0_a = 32'hF0F0_00FF; bus.req0_b = 32'h0FF0_FF0F;
    bus.rsp_ready = 1'b1;
    #1;
    chk("s1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("s1_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    chk("s1_exec_busy",  {31'd0, bus.busy},       32'd1);
    chk("s1_exec_rdy0",  {31'd0, bus.req0_ready}, 32'd0);
    chk("s1_alu_sel",    {30'd0, bus.alu_sel},    32'd2);
    chk("s1_alu_a",      bus.alu_a,               32'hF0F0_00FF);
    chk("s1_alu_b",      bus.alu_b,               32'h0FF0_FF0F);
    chk("s1_exec_rspv",  {31'd0, bus.rsp_valid},  32'd0);
    tick();
    chk("s1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("s1_rsp_data",  bus.rsp_data,           32'h00F0_000F);
    chk("s1_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
    tick();
    chk("s1_done_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    chk("s1_done_busy", {31'd0, bus.busy},      32'd0);

    // Alternating grants with both ports requesting
    pulse_reset();
    tick();
    bus.req0_valid = 1'b1; bus.req0_sel = 2'b11;
    bus.req1_valid = 1'b1; bus.req1_sel = 2'b01; bus.req1_c = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("s2_op%0d_ready0", k), {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("s2_op%0d_ready1", k), {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("s2_op%0d_exec_rdy", k), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      tick();
      chk($sformatf("s2_op%0d_rspv", k), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("s2_op%0d_data", k), bus.rsp_data, (k % 2 == 1) ? 32'h1234_5678 : 32'hFFF0_FFFF);
      chk($sformatf("s2_op%0d_id", k),   {31'd0, bus.rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("s2_op%0d_idle", k), {31'd0, bus.rsp_valid}, 32'd0);
    end

    // Response backpressure
    #1;
    chk("s3_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("s3_hold%0d_rspv", k), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("s3_hold%0d_data", k), bus.rsp_data, 32'hFFF0_FFFF);
      chk($sformatf("s3_hold%0d_id", k),   {31'd0, bus.rsp_id}, 32'd0);
      chk($sformatf("s3_hold%0d_rdy", k),  {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      chk($sformatf("s3_hold%0d_busy", k), {31'd0, bus.busy}, 32'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("s3_rel_rspv",   {31'd0, bus.rsp_valid},  32'd0);
    chk("s3_rel_busy",   {31'd0, bus.busy},       32'd0);
    chk("s3_rel_ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("s3_rel_ready0", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("s3_p1_alu_sel", {30'd0, bus.alu_sel}, 32'd1);
    chk("s3_p1_alu_c",   bus.alu_c,            32'h1234_5678);
    tick();
    chk("s3_p1_data", bus.rsp_data,        32'h1234_5678);
    chk("s3_p1_id",   {31'd0, bus.rsp_id}, 32'd1);
    tick();

    // Lone port-1 request wins despite the reset pointer
    pulse_reset();
    tick();
    bus.req1_valid = 1'b1; bus.req1_sel = 2'b00; bus.req1_c = 32'hDEAD_BEEF;
    #1;
    chk("s4_ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("s4_ready0", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("s4_rspv", {31'd0, bus.rsp_valid}, 32'd1);
    chk("s4_data", bus.rsp_data,           32'hDEAD_BEEF);
    chk("s4_id",   {31'd0, bus.rsp_id},    32'd1);
    tick();
    chk("s4_idle", {31'd0, bus.busy}, 32'd0);
    bus.req0_valid = 1'b1; bus.req0_sel = 2'b10;
    bus.req1_valid = 1'b1;
    #1;
    chk("s4_tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("s4_tie_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    tick();
    chk("s4_tie_data", bus.rsp_data,        32'h00F0_000F);
    chk("s4_tie_id",   {31'd0, bus.rsp_id}, 32'd0);
    tick();

    // Asynchronous reset while in EXEC
    #1;
    chk("s5_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    chk("s5_exec_busy", {31'd0, bus.busy},    32'd1);
    chk("s5_exec_sel",  {30'd0, bus.alu_sel}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    chk("s5_rst_busy", {31'd0, bus.busy},      32'd0);
    chk("s5_rst_alu_c", bus.alu_c,             32'd0);
    chk("s5_rst_alu_sel", {30'd0, bus.alu_sel}, 32'd0);
    tick();
    chk("s5_rst_norsp", {31'd0, bus.rsp_valid}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("s5_post_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("s5_post_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("s5_post_sel", {30'd0, bus.alu_sel}, 32'd2);
    tick();
    chk("s5_post_data", bus.rsp_data,        32'h00F0_000F);
    chk("s5_post_id",   {31'd0, bus.rsp_id}, 32'd0);
    tick();

    // Port 1 raises then drops valid while port 0 sits in RESP
    bus.req0_valid = 1'b1; bus.req0_sel = 2'b10;
    bus.req0_a = 32'hFFFF_0000; bus.req0_b = 32'h0F0F_0F0F;
    #1;
    chk("s6_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    tick();
    chk("s6_data", bus.rsp_data,        32'h0F0F_0000);
    chk("s6_id",   {31'd0, bus.rsp_id}, 32'd0);
    bus.req1_valid = 1'b1; bus.req1_sel = 2'b00; bus.req1_c = 32'hCAFE_0001;
    #1;
    chk("s6_resp_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("s6_alu_sel",  {30'd0, bus.alu_sel}, 32'd2);
    chk("s6_alu_a",    bus.alu_a,            32'hFFFF_0000);
    chk("s6_alu_c",    bus.alu_c,            32'd0);
    chk("s6_held_rspv", {31'd0, bus.rsp_valid}, 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    chk("s6_idle_busy", {31'd0, bus.busy},      32'd0);
    chk("s6_idle_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    tick();
    chk("s6_end_busy",    {31'd0, bus.busy},      32'd0);
    chk("s6_end_rspv",    {31'd0, bus.rsp_valid}, 32'd0);
    chk("s6_end_alu_sel", {30'd0, bus.alu_sel},   32'd2);
    chk("s6_end_alu_a",   bus.alu_a,              32'hFFFF_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
